approx_error_monitor: RTL and testbench
=======================================

APPROX_ERROR_MONITOR -- requirements
Module: approx_error_monitor

Interface
REQ-001 Parameter WINDOW, default 1024: samples per report window, legal range 1..2^32-1.
REQ-002 Parameter SUM_W, default 96: width of the error-distance accumulator, legal range 64..96.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port s_valid, input, 1: sample offered.
REQ-006 Port s_ready, output, 1: block accepts a sample this cycle.
REQ-007 Port s_approx, input, 64: product from the 32x32 approximate multiplier.
REQ-008 Port s_exact, input, 64: exact product of the same operands.
REQ-009 Port flush, input, 1: single-cycle request to close the window early.
REQ-010 Port m_valid, output, 1: report available.
REQ-011 Port m_ready, input, 1: report consumed.
REQ-012 Port m_samples, output, 32: samples in the reported window.
REQ-013 Port m_errcnt, output, 32: samples with s_approx != s_exact.
REQ-014 Port m_sum, output, SUM_W: sum of absolute error distances.
REQ-015 Port m_max, output, 64: largest absolute error distance.
REQ-016 Port m_ovf, output, 1: m_sum saturated in this window.

Function
REQ-017 The block SHALL accept a sample only on a cycle where s_valid and s_ready are both 1.
REQ-018 Stage 1 SHALL register ED = |s_approx - s_exact| as the larger operand minus the smaller one (64-bit unsigned, no wrap), plus err = (s_approx != s_exact) and a valid bit, at the accepting edge.
REQ-019 Stage 2 SHALL update the accumulators one edge after stage 1 when the stage-1 valid bit is set:
- samples += 1
- errcnt += err
- max = max(max, ED)
- sum += ED
REQ-020 Sum overflow: sum SHALL saturate at 2^SUM_W-1, and the sticky ovf SHALL be set.
REQ-021 The state machine SHALL have three states: ACCUM, DRAIN, REPORT.
REQ-022 s_ready SHALL be 1 only in ACCUM.
REQ-023 ACCUM -> DRAIN SHALL occur at the edge that accepts the WINDOW-th sample, or at an edge with flush=1 when samples already committed or in flight are at least 1.
REQ-024 flush in ACCUM with zero samples (committed, in flight and accepted) SHALL be ignored; flush outside ACCUM SHALL be ignored.
REQ-025 flush and an accept in the same cycle SHALL include that sample in the window.
REQ-026 DRAIN SHALL last exactly one cycle, go to REPORT, and let the last sample commit at that edge.
REQ-027 m_valid SHALL be 1 exactly in REPORT: two cycles after the acceptance cycle of the last sample.
REQ-028 m_samples, m_errcnt, m_sum, m_max and m_ovf SHALL reflect the accumulators and stay stable while m_valid=1 and m_ready=0.
REQ-029 On an edge with m_valid=1 and m_ready=1, all accumulators SHALL clear and the state SHALL return to ACCUM, so s_ready=1 on the next cycle.
REQ-030 s_valid, s_approx and s_exact SHALL have no effect outside ACCUM.
REQ-031 m_ready SHALL have no effect outside REPORT.
REQ-032 m_max SHALL reach 2^64-1 without wrap.
REQ-033 The errcnt and samples counters SHALL never exceed WINDOW.

Reset
REQ-034 While rst=1 at an edge, the block SHALL enter ACCUM and clear all accumulators and the stage-1 valid bit.
REQ-035 During reset, s_ready=0, m_valid=0 and all report outputs = 0.
REQ-036 s_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-037 A reset mid-window or mid-report SHALL discard partial results; no report is produced for them.

Verification
REQ-038 WINDOW=4, four accepts with approx=exact=0x1234:
- m_valid rises 2 cycles after the 4th accept
- samples=4, errcnt=0, sum=0, max=0, ovf=0
REQ-039 WINDOW=3, (approx,exact) = (100,90), (5,15), (0, 0xFFFF_FFFF_FFFF_FFFF):
- errcnt=3
- max=0xFFFF_FFFF_FFFF_FFFF
- sum=0x1_0000_0000_0000_0013
REQ-040 WINDOW=2, report held with m_ready=0 for 5 cycles while s_valid=1:
- outputs stable, s_ready=0, no sample absorbed
- after m_ready=1: s_ready=1 next cycle, next report counts only new samples
REQ-041 WINDOW=8, 2 accepts, then flush together with a 3rd accept:
- samples=3
- a flush with zero samples yields no m_valid
REQ-042 SUM_W=64, WINDOW=2, two samples with ED = 2^64-1:
- sum=0xFFFF_FFFF_FFFF_FFFF, ovf=1
REQ-043 rst pulsed after 3 of 4 samples, then 4 clean samples:
- single report with samples=4 from the clean samples only

Source files
------------

// File: rtl/approx_error_monitor.sv
// Windowed error statistics for an approximate 32x32 multiplier: compares approx vs exact
// products through a two-stage pipeline and reports count, mismatches, error sum and max.
module approx_error_monitor #(
   parameter int unsigned WINDOW = 1024,
   parameter int unsigned SUM_W  = 96
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [63:0]      s_approx,
   input  logic [63:0]      s_exact,
   input  logic             flush,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [31:0]      m_samples,
   output logic [31:0]      m_errcnt,
   output logic [SUM_W-1:0] m_sum,
   output logic [63:0]      m_max,
   output logic             m_ovf
);

   typedef enum logic [1:0] {ACCUM, DRAIN, REPORT} state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_s1_valid;
   logic             r_s1_err;
   logic [63:0]      r_s1_ed;

   logic [31:0]      r_samples;
   logic [31:0]      r_errcnt;
   logic [SUM_W-1:0] r_sum;
   logic [63:0]      r_max;
   logic             r_ovf;

   logic             w_accept;
   logic             w_last;
   logic             w_flush_go;
   logic [32:0]      w_taken;
   logic [63:0]      w_ed;
   logic [SUM_W:0]   w_sum_ext;

   assign w_accept   = s_valid & s_ready;
   // Samples already committed plus the one sitting in stage 1.
   assign w_taken    = {1'b0, r_samples} + {32'b0, r_s1_valid};
   assign w_last     = w_accept && ((w_taken + 33'd1) == 33'(WINDOW));
   assign w_flush_go = flush && ((w_taken != '0) || w_accept);
   assign w_ed       = (s_approx >= s_exact) ? (s_approx - s_exact) : (s_exact - s_approx);
   assign w_sum_ext  = {1'b0, r_sum} + (SUM_W+1)'(r_s1_ed);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ACCUM;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ACCUM:   if (w_last || w_flush_go) w_state_nxt = DRAIN;
         DRAIN:   w_state_nxt = REPORT;
         REPORT:  if (m_ready) w_state_nxt = ACCUM;
         default: w_state_nxt = ACCUM;
      endcase
   end

   always_comb begin
      s_ready   = (r_state == ACCUM) && !rst;
      m_valid   = (r_state == REPORT) && !rst;
      m_samples = rst ? '0 : r_samples;
      m_errcnt  = rst ? '0 : r_errcnt;
      m_sum     = rst ? '0 : r_sum;
      m_max     = rst ? '0 : r_max;
      m_ovf     = rst ? 1'b0 : r_ovf;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_err   <= 1'b0;
         r_s1_ed    <= '0;
         r_samples  <= '0;
         r_errcnt   <= '0;
         r_sum      <= '0;
         r_max      <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_ed  <= w_ed;
            r_s1_err <= (s_approx != s_exact);
         end
         // Stage 1 is always empty in REPORT, so clear and update never collide.
         if ((r_state == REPORT) && m_ready) begin
            r_samples <= '0;
            r_errcnt  <= '0;
            r_sum     <= '0;
            r_max     <= '0;
            r_ovf     <= 1'b0;
         end else if (r_s1_valid) begin
            r_samples <= r_samples + 32'd1;
            r_errcnt  <= r_errcnt + {31'b0, r_s1_err};
            if (r_s1_ed > r_max) r_max <= r_s1_ed;
            if (w_sum_ext[SUM_W]) begin
               r_sum <= '1;
               r_ovf <= 1'b1;
            end else begin
               r_sum <= w_sum_ext[SUM_W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_approx_error_monitor.sv
// Bench for approx_error_monitor: five instances with different WINDOW/SUM_W share stimulus;
// each scenario resets them all and checks one instance against a reference model.
module tb_approx_error_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        flush;
   logic        m_ready;
   logic [63:0] s_approx;
   logic [63:0] s_exact;
   logic [4:0]  s_ready;
   logic [4:0]  m_valid;
   logic [4:0]  m_ovf;
   logic [31:0] m_samples [5];
   logic [31:0] m_errcnt [5];
   logic [63:0] m_max [5];
   logic [95:0] m_sum [4];
   logic [63:0] sum64;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] qa[$];
   logic [63:0] qe[$];

   always #5 clk = ~clk;

   approx_error_monitor #(.WINDOW(4), .SUM_W(96)) u0 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready[0]), .s_approx(s_approx),
      .s_exact(s_exact), .flush(flush), .m_valid(m_valid[0]), .m_ready(m_ready),
      .m_samples(m_samples[0]), .m_errcnt(m_errcnt[0]), .m_sum(m_sum[0]), .m_max(m_max[0]),
      .m_ovf(m_ovf[0]));
   approx_error_monitor #(.WINDOW(3), .SUM_W(96)) u1 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready[1]), .s_approx(s_approx),
      .s_exact(s_exact), .flush(flush), .m_valid(m_valid[1]), .m_ready(m_ready),
      .m_samples(m_samples[1]), .m_errcnt(m_errcnt[1]), .m_sum(m_sum[1]), .m_max(m_max[1]),
      .m_ovf(m_ovf[1]));
   approx_error_monitor #(.WINDOW(2), .SUM_W(96)) u2 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready[2]), .s_approx(s_approx),
      .s_exact(s_exact), .flush(flush), .m_valid(m_valid[2]), .m_ready(m_ready),
      .m_samples(m_samples[2]), .m_errcnt(m_errcnt[2]), .m_sum(m_sum[2]), .m_max(m_max[2]),
      .m_ovf(m_ovf[2]));
   approx_error_monitor #(.WINDOW(8), .SUM_W(96)) u3 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready[3]), .s_approx(s_approx),
      .s_exact(s_exact), .flush(flush), .m_valid(m_valid[3]), .m_ready(m_ready),
      .m_samples(m_samples[3]), .m_errcnt(m_errcnt[3]), .m_sum(m_sum[3]), .m_max(m_max[3]),
      .m_ovf(m_ovf[3]));
   approx_error_monitor #(.WINDOW(2), .SUM_W(64)) u4 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready[4]), .s_approx(s_approx),
      .s_exact(s_exact), .flush(flush), .m_valid(m_valid[4]), .m_ready(m_ready),
      .m_samples(m_samples[4]), .m_errcnt(m_errcnt[4]), .m_sum(sum64), .m_max(m_max[4]),
      .m_ovf(m_ovf[4]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] e, input logic f);
      s_valid  = v;
      s_approx = a;
      s_exact  = e;
      flush    = f;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_ready = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic release_report();
      drive(1'b0, '0, '0, 1'b0);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [63:0] absd(input logic [63:0] a, input logic [63:0] b);
      return (a > b) ? a - b : b - a;
   endfunction

   task automatic gen_pair(output logic [63:0] a, output logic [63:0] e);
      a = rnd64();
      case ($urandom_range(0, 3))
         0: e = a;
         1: e = a + 64'($urandom_range(0, 1000)) - 64'd500;
         2: e = rnd64();
         default: begin
            a = ($urandom_range(0, 1) == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
            e = ($urandom_range(0, 1) == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : rnd64();
         end
      endcase
   endtask

   // Window statistics straight from the definition: wide exact sum, then clamp.
   task automatic model_calc(input int unsigned sumw, output logic [31:0] n, output logic [31:0] err,
                             output logic [95:0] sum, output logic [63:0] mx, output logic ov);
      logic [127:0] s;
      logic [127:0] lim;
      logic [63:0]  d;
      n = 0; err = 0; s = 0; mx = 0;
      foreach (qa[i]) begin
         d = absd(qa[i], qe[i]);
         n++;
         if (qa[i] != qe[i]) err++;
         s += 128'(d);
         if (d > mx) mx = d;
      end
      lim = (128'd1 << sumw) - 128'd1;
      ov  = (s > lim);
      sum = ov ? lim[95:0] : s[95:0];
   endtask

   task automatic test_reset();
      logic [95:0] sv;
      rst = 1'b1;
      m_ready = 1'b0;
      drive(1'b1, 64'h5, 64'h7, 1'b1);
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         sv = (k < 4) ? m_sum[k] : {32'b0, sum64};
         n_tests++;
         if (s_ready[k] !== 1'b0 || m_valid[k] !== 1'b0 || m_samples[k] !== 0 || m_errcnt[k] !== 0 ||
             sv !== '0 || m_max[k] !== 0 || m_ovf[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state inst%0d: rdy=%b vld=%b n=%0d err=%0d sum=%h max=%h ovf=%b, want all 0",
                     k, s_ready[k], m_valid[k], m_samples[k], m_errcnt[k], sv, m_max[k], m_ovf[k]);
         end
      end
      drive(1'b0, '0, '0, 1'b0);
      rst = 1'b0;
      #1;
      n_tests++;
      if (s_ready !== 5'b11111 || m_valid !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_release: s_ready=%b m_valid=%b, want 11111 00000", s_ready, m_valid);
      end
   endtask

   task automatic test_no_error();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'h1234, 64'h1234, 1'b0);
         n_tests++;
         if (s_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL noerr_ready[%0d]: s_ready=%b, want 1", i, s_ready[0]);
         end
         tick();
      end
      drive(1'b0, '0, '0, 1'b0);
      n_tests++;
      if (m_valid[0] !== 1'b0 || s_ready[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL noerr_drain: m_valid=%b s_ready=%b, want 0 0", m_valid[0], s_ready[0]);
      end
      tick();
      n_tests++;
      if (m_valid[0] !== 1'b1 || m_samples[0] !== 4 || m_errcnt[0] !== 0 || m_sum[0] !== '0 ||
          m_max[0] !== 0 || m_ovf[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL noerr_report: vld=%b n=%0d err=%0d sum=%h max=%h ovf=%b, want 1 4 0 0 0 0",
                  m_valid[0], m_samples[0], m_errcnt[0], m_sum[0], m_max[0], m_ovf[0]);
      end
      release_report();
      n_tests++;
      if (s_ready[0] !== 1'b1 || m_valid[0] !== 1'b0 || m_samples[0] !== 0) begin
         n_fail++;
         $display("FAIL noerr_release: rdy=%b vld=%b n=%0d, want 1 0 0", s_ready[0], m_valid[0], m_samples[0]);
      end
   endtask

   task automatic test_big_error();
      do_reset();
      drive(1'b1, 64'd100, 64'd90, 1'b0); tick();
      drive(1'b1, 64'd5, 64'd15, 1'b0); tick();
      drive(1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0); tick();
      drive(1'b0, '0, '0, 1'b0); tick();
      n_tests++;
      if (m_valid[1] !== 1'b1 || m_samples[1] !== 3 || m_errcnt[1] !== 3 ||
          m_max[1] !== 64'hFFFF_FFFF_FFFF_FFFF || m_sum[1] !== 96'h1_0000_0000_0000_0013 || m_ovf[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL bigerr_report: vld=%b n=%0d err=%0d sum=%h max=%h ovf=%b, want 1 3 3 100000000000000013 ffffffffffffffff 0",
                  m_valid[1], m_samples[1], m_errcnt[1], m_sum[1], m_max[1], m_ovf[1]);
      end
      release_report();
   endtask

   task automatic test_backpressure();
      logic [63:0] a, e, mx;
      logic [31:0] n, err;
      logic [95:0] sum;
      logic        ov;
      do_reset();
      for (int pass = 0; pass < 2; pass++) begin
         qa.delete(); qe.delete();
         for (int i = 0; i < 2; i++) begin
            gen_pair(a, e);
            drive(1'b1, a, e, 1'b0);
            qa.push_back(a); qe.push_back(e);
            tick();
         end
         drive(1'b0, '0, '0, 1'b0);
         tick();
         model_calc(96, n, err, sum, mx, ov);
         for (int c = 0; c < 5; c++) begin
            gen_pair(a, e);
            drive(1'b1, a, e, 1'b0);
            n_tests++;
            if (m_valid[2] !== 1'b1 || s_ready[2] !== 1'b0 || m_samples[2] !== n || m_errcnt[2] !== err ||
                m_sum[2] !== sum || m_max[2] !== mx || m_ovf[2] !== ov) begin
               n_fail++;
               $display("FAIL hold[%0d.%0d]: vld=%b rdy=%b n=%0d err=%0d sum=%h max=%h ovf=%b, want 1 0 %0d %0d %h %h %b",
                        pass, c, m_valid[2], s_ready[2], m_samples[2], m_errcnt[2], m_sum[2], m_max[2], m_ovf[2],
                        n, err, sum, mx, ov);
            end
            tick();
         end
         release_report();
         n_tests++;
         if (s_ready[2] !== 1'b1 || m_valid[2] !== 1'b0 || m_samples[2] !== 0) begin
            n_fail++;
            $display("FAIL hold_release[%0d]: rdy=%b vld=%b n=%0d, want 1 0 0", pass, s_ready[2], m_valid[2], m_samples[2]);
         end
      end
   endtask

   task automatic test_flush();
      logic [63:0] a, e, mx;
      logic [31:0] n, err;
      logic [95:0] sum;
      logic        ov;
      logic        seen;
      do_reset();
      drive(1'b0, '0, '0, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b0);
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (m_valid[3] !== 1'b0 || s_ready[3] !== 1'b1) seen = 1'b1;
         tick();
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_empty: left ACCUM after empty flush (seen=%b), want 0", seen);
      end
      qa.delete(); qe.delete();
      for (int i = 0; i < 3; i++) begin
         gen_pair(a, e);
         drive(1'b1, a, e, i == 2);
         qa.push_back(a); qe.push_back(e);
         tick();
      end
      drive(1'b0, '0, '0, 1'b0);
      n_tests++;
      if (m_valid[3] !== 1'b0 || s_ready[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_drain: vld=%b rdy=%b, want 0 0", m_valid[3], s_ready[3]);
      end
      tick();
      model_calc(96, n, err, sum, mx, ov);
      drive(1'b0, '0, '0, 1'b1);
      n_tests++;
      if (m_valid[3] !== 1'b1 || m_samples[3] !== 3 || m_errcnt[3] !== err || m_sum[3] !== sum ||
          m_max[3] !== mx || m_ovf[3] !== ov) begin
         n_fail++;
         $display("FAIL flush_report: vld=%b n=%0d err=%0d sum=%h max=%h ovf=%b, want 1 3 %0d %h %h %b",
                  m_valid[3], m_samples[3], m_errcnt[3], m_sum[3], m_max[3], m_ovf[3], err, sum, mx, ov);
      end
      tick();
      n_tests++;
      if (m_valid[3] !== 1'b1 || m_samples[3] !== 3) begin
         n_fail++;
         $display("FAIL flush_in_report: vld=%b n=%0d, want 1 3", m_valid[3], m_samples[3]);
      end
      release_report();
   endtask

   task automatic test_saturate();
      do_reset();
      drive(1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0); tick();
      drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0); tick();
      drive(1'b0, '0, '0, 1'b0); tick();
      n_tests++;
      if (m_valid[4] !== 1'b1 || m_samples[4] !== 2 || m_errcnt[4] !== 2 || sum64 !== 64'hFFFF_FFFF_FFFF_FFFF ||
          m_max[4] !== 64'hFFFF_FFFF_FFFF_FFFF || m_ovf[4] !== 1'b1) begin
         n_fail++;
         $display("FAIL saturate: vld=%b n=%0d err=%0d sum=%h max=%h ovf=%b, want 1 2 2 ffffffffffffffff ffffffffffffffff 1",
                  m_valid[4], m_samples[4], m_errcnt[4], sum64, m_max[4], m_ovf[4]);
      end
      release_report();
   endtask

   task automatic test_reset_mid();
      logic [63:0] a, e, mx;
      logic [31:0] n, err;
      logic [95:0] sum;
      logic        ov;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         gen_pair(a, e);
         drive(1'b1, a, e, 1'b0);
         tick();
      end
      rst = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      n_tests++;
      if (m_valid[0] !== 1'b0 || s_ready[0] !== 1'b1 || m_samples[0] !== 0) begin
         n_fail++;
         $display("FAIL midrst_clear: vld=%b rdy=%b n=%0d, want 0 1 0", m_valid[0], s_ready[0], m_samples[0]);
      end
      qa.delete(); qe.delete();
      for (int i = 0; i < 4; i++) begin
         gen_pair(a, e);
         drive(1'b1, a, e, 1'b0);
         qa.push_back(a); qe.push_back(e);
         tick();
      end
      drive(1'b0, '0, '0, 1'b0);
      tick();
      model_calc(96, n, err, sum, mx, ov);
      n_tests++;
      if (m_valid[0] !== 1'b1 || m_samples[0] !== 4 || m_errcnt[0] !== err || m_sum[0] !== sum ||
          m_max[0] !== mx || m_ovf[0] !== ov) begin
         n_fail++;
         $display("FAIL midrst_report: vld=%b n=%0d err=%0d sum=%h max=%h ovf=%b, want 1 4 %0d %h %h %b",
                  m_valid[0], m_samples[0], m_errcnt[0], m_sum[0], m_max[0], m_ovf[0], err, sum, mx, ov);
      end
      release_report();
   endtask

   task automatic test_random();
      logic [63:0] a, e, mx;
      logic [31:0] n, err;
      logic [95:0] sum;
      logic        ov, v, f, done;
      int          cnt, guard;
      do_reset();
      for (int w = 0; w < 25; w++) begin
         qa.delete(); qe.delete();
         cnt = 0; done = 1'b0; guard = 0;
         while (!done && guard < 200) begin
            guard++;
            v = ($urandom_range(0, 3) != 0);
            f = (cnt > 0 || v) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) == 0);
            gen_pair(a, e);
            drive(v, a, e, f);
            n_tests++;
            if (s_ready[0] !== 1'b1) begin
               n_fail++;
               $display("FAIL rnd_ready[w%0d]: s_ready=%b, want 1", w, s_ready[0]);
            end
            tick();
            if (v) begin
               qa.push_back(a); qe.push_back(e);
               cnt++;
            end
            if (cnt == 4 || (f && cnt > 0)) done = 1'b1;
         end
         gen_pair(a, e);
         drive(1'b1, a, e, 1'b1);
         n_tests++;
         if (m_valid[0] !== 1'b0 || s_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_drain[w%0d]: vld=%b rdy=%b, want 0 0 (guard=%0d)", w, m_valid[0], s_ready[0], guard);
         end
         tick();
         for (int h = $urandom_range(0, 2); h > 0; h--) begin
            gen_pair(a, e);
            drive($urandom_range(0, 1) == 1, a, e, $urandom_range(0, 1) == 1);
            tick();
         end
         model_calc(96, n, err, sum, mx, ov);
         n_tests++;
         if (m_valid[0] !== 1'b1 || m_samples[0] !== n || m_errcnt[0] !== err || m_sum[0] !== sum ||
             m_max[0] !== mx || m_ovf[0] !== ov) begin
            n_fail++;
            $display("FAIL rnd_report[w%0d]: vld=%b n=%0d err=%0d sum=%h max=%h ovf=%b, want 1 %0d %0d %h %h %b",
                     w, m_valid[0], m_samples[0], m_errcnt[0], m_sum[0], m_max[0], m_ovf[0], n, err, sum, mx, ov);
         end
         release_report();
      end
   endtask

   initial begin
      rst = 1'b1;
      m_ready = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      test_reset();
      test_no_error();
      test_big_error();
      test_backpressure();
      test_flush();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
